// File: rtl/sdram_init.sv
// SDRAM power-up initialisation sequencer: waits for PLL lock, then issues
// PRECHARGE ALL, REFRESH_COUNT auto refreshes and LOAD MODE before handing over the bus.
module sdram_init #(
  parameter int unsigned WAIT_CYCLES   = 5000,
  parameter int unsigned T_RP          = 1,
  parameter int unsigned T_RFC         = 2,
  parameter int unsigned T_MRD         = 2,
  parameter int unsigned REFRESH_COUNT = 8,
  parameter logic [12:0] MODE_REG      = 13'h020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pll_locked,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [1:0]  ba,
  output logic [12:0] addr,
  output logic        init_done
);

  typedef enum logic [3:0] {
    WAIT_LOCK, POWERUP, PRECHARGE, WAIT_RP, REFRESH,
    WAIT_RFC, LOAD_MODE, WAIT_MRD, DONE
  } state_t;

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;
  localparam logic [3:0] RC        = 4'(REFRESH_COUNT);

  state_t      state;
  logic [15:0] cnt;
  logic [3:0]  ref_cnt;
  logic [3:0]  cmd;
  logic        sync1;
  logic        lock_s;

  assign {cs_n, ras_n, cas_n, we_n} = cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  // Outputs are loaded together with the state they belong to, so each
  // branch sets the bus for the state being entered; defaults give a NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      ref_cnt   <= '0;
      cke       <= 1'b0;
      cmd       <= CMD_DESEL;
      ba        <= '0;
      addr      <= '0;
      init_done <= 1'b0;
    end else begin
      cke       <= 1'b1;
      cmd       <= CMD_NOP;
      ba        <= '0;
      addr      <= '0;
      init_done <= 1'b0;
      if (!lock_s) begin
        state   <= WAIT_LOCK;
        cnt     <= '0;
        ref_cnt <= '0;
        cke     <= 1'b0;
        cmd     <= CMD_DESEL;
      end else begin
        case (state)
          WAIT_LOCK: begin
            state <= POWERUP;
            cnt   <= 16'(WAIT_CYCLES - 1);
          end
          POWERUP: begin
            if (cnt == '0) begin
              state <= PRECHARGE;
              cmd   <= CMD_PRE;
              addr  <= 13'h400;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          PRECHARGE: begin
            state <= WAIT_RP;
            cnt   <= 16'(T_RP - 1);
          end
          WAIT_RP: begin
            if (cnt == '0) begin
              state   <= REFRESH;
              cmd     <= CMD_REF;
              ref_cnt <= ref_cnt + 4'd1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          REFRESH: begin
            state <= WAIT_RFC;
            cnt   <= 16'(T_RFC - 1);
          end
          WAIT_RFC: begin
            if (cnt != '0) begin
              cnt <= cnt - 16'd1;
            end else if (ref_cnt == RC) begin
              state <= LOAD_MODE;
              cmd   <= CMD_LMR;
              addr  <= MODE_REG;
            end else begin
              state   <= REFRESH;
              cmd     <= CMD_REF;
              ref_cnt <= ref_cnt + 4'd1;
            end
          end
          LOAD_MODE: begin
            state <= WAIT_MRD;
            cnt   <= 16'(T_MRD - 1);
          end
          WAIT_MRD: begin
            if (cnt == '0) begin
              state     <= DONE;
              init_done <= 1'b1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          DONE: init_done <= 1'b1;
          default: begin
            state <= WAIT_LOCK;
            cke   <= 1'b0;
            cmd   <= CMD_DESEL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_init.sv
// Scoreboard bench for sdram_init: two configurations share clock, reset and lock;
// expected command events come from a timeline model and are matched by a monitor.
module tb_sdram_init;

  typedef struct {
    int          kind;   // 0 powerup, 1 precharge, 2 refresh, 3 load mode, 4 done
    logic [12:0] addr;
    int          cyc;
  } ev_t;

  localparam int W_P[2]    = '{10, 1};
  localparam int TRP_P[2]  = '{1, 1};
  localparam int TRFC_P[2] = '{2, 1};
  localparam int TMRD_P[2] = '{2, 2};
  localparam int RC_P[2]   = '{8, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]       cke_w, csn_w, rasn_w, casn_w, wen_w, done_w;
  logic [1:0][1:0]  ba_w;
  logic [1:0][12:0] addr_w;

  ev_t expq[2][$];

  sdram_init #(.WAIT_CYCLES(10), .T_RP(1), .T_RFC(2), .T_MRD(2), .REFRESH_COUNT(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .cke(cke_w[0]), .cs_n(csn_w[0]), .ras_n(rasn_w[0]), .cas_n(casn_w[0]), .we_n(wen_w[0]),
    .ba(ba_w[0]), .addr(addr_w[0]), .init_done(done_w[0]));

  sdram_init #(.WAIT_CYCLES(1), .T_RP(1), .T_RFC(1), .T_MRD(2), .REFRESH_COUNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .cke(cke_w[1]), .cs_n(csn_w[1]), .ras_n(rasn_w[1]), .cas_n(casn_w[1]), .we_n(wen_w[1]),
    .ba(ba_w[1]), .addr(addr_w[1]), .init_done(done_w[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Timeline: lock seen by the FSM two edges after pll_locked, powerup on the third.
  // Lock dropped after edge drop leaves the sequence at edge drop+3.
  function automatic void push_seq(int m, int lk, int drop);
    int t0, lim, r;
    ev_t e;
    t0  = lk + 3;
    lim = (drop < 0) ? 32'h3fffffff : drop + 2 - t0;
    for (int k = 0; k < 4 + RC_P[m]; k++) begin
      e.addr = 13'h000;
      if (k == 0)                   begin e.kind = 0; r = 0; end
      else if (k == 1)              begin e.kind = 1; r = W_P[m]; e.addr = 13'h400; end
      else if (k < 2 + RC_P[m])     begin e.kind = 2; r = W_P[m] + 1 + TRP_P[m] + (k - 2) * (1 + TRFC_P[m]); end
      else if (k == 2 + RC_P[m])    begin e.kind = 3; r = W_P[m] + 1 + TRP_P[m] + RC_P[m] * (1 + TRFC_P[m]); e.addr = 13'h020; end
      else                          begin e.kind = 4; r = W_P[m] + 2 + TRP_P[m] + RC_P[m] * (1 + TRFC_P[m]) + TMRD_P[m]; end
      e.cyc = t0 + r;
      if (r <= lim) expq[m].push_back(e);
    end
  endfunction

  task automatic monitor();
    logic [1:0] pcke = '0, pdone = '0;
    logic [3:0] cmd;
    ev_t a, x;
    bit  hit;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        cmd = {csn_w[m], rasn_w[m], casn_w[m], wen_w[m]};
        checks++;
        if ((cmd == 4'b0111 || cmd == 4'b1111) ? (addr_w[m] != 0 || ba_w[m] != 0) : (ba_w[m] != 0)) begin
          errors++;
          $display("FAIL idle_bus dut%0d cyc %0d: cmd %b addr %h ba %0d, required addr 0 ba 0", m, cyc, cmd, addr_w[m], ba_w[m]);
        end
        if (!cke_w[m]) begin
          checks++;
          if (cmd != 4'b1111 || done_w[m]) begin
            errors++;
            $display("FAIL cke_low_bus dut%0d cyc %0d: cmd %b done %b, required 1111 / 0", m, cyc, cmd, done_w[m]);
          end
        end
        for (int k = 0; k < 3; k++) begin
          hit = 1'b0;
          a.addr = addr_w[m];
          a.cyc  = cyc;
          if (k == 0 && cke_w[m] && !pcke[m]) begin hit = 1'b1; a.kind = 0; end
          if (k == 1 && cmd != 4'b0111 && cmd != 4'b1111) begin
            hit = 1'b1;
            a.kind = (cmd == 4'b0010) ? 1 : (cmd == 4'b0001) ? 2 : (cmd == 4'b0000) ? 3 : 9;
          end
          if (k == 2 && done_w[m] && !pdone[m]) begin hit = 1'b1; a.kind = 4; end
          if (hit) begin
            checks++;
            if (expq[m].size() == 0) begin
              errors++;
              $display("FAIL unexpected_event dut%0d: kind %0d addr %h at cyc %0d, required none", m, a.kind, a.addr, a.cyc);
            end else begin
              x = expq[m].pop_front();
              if (a.kind != x.kind || a.addr != x.addr || a.cyc != x.cyc) begin
                errors++;
                $display("FAIL event dut%0d: got kind %0d addr %h cyc %0d, required kind %0d addr %h cyc %0d",
                         m, a.kind, a.addr, a.cyc, x.kind, x.addr, x.cyc);
              end
            end
          end
        end
      end
      pcke  = cke_w;
      pdone = done_w;
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drained(string name);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (expq[m].size() != 0) begin
        errors++;
        $display("FAIL %s dut%0d: %0d expected events never seen, required 0", name, m, expq[m].size());
        expq[m].delete();
      end
    end
  endtask

  task automatic check_idle(string name);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (cke_w[m] || done_w[m] || {csn_w[m], rasn_w[m], casn_w[m], wen_w[m]} != 4'b1111 ||
          addr_w[m] != 0 || ba_w[m] != 0) begin
        errors++;
        $display("FAIL %s dut%0d: cke %b done %b cmd %b addr %h ba %0d, required 0 0 1111 0 0", name, m,
                 cke_w[m], done_w[m], {csn_w[m], rasn_w[m], casn_w[m], wen_w[m]}, addr_w[m], ba_w[m]);
      end
    end
  endtask

  task automatic wait_done(string name, int limit);
    int n = 0;
    while (done_w != 2'b11 && n < limit) begin tick(); n++; end
    checks++;
    if (done_w != 2'b11) begin
      errors++;
      $display("FAIL %s: init_done %b after %0d cycles, required 11", name, done_w, limit);
    end
    tick(3);
    drained(name);
  endtask

  task automatic lock_and_drop(int drop_rel, int idle);
    int lk;
    tick(idle);
    pll_locked = 1'b1;
    lk = cyc;
    for (int m = 0; m < 2; m++) push_seq(m, lk, (drop_rel < 0) ? -1 : lk + drop_rel);
    if (drop_rel >= 0) begin
      while (cyc < lk + drop_rel) tick();
      pll_locked = 1'b0;
      tick(6);
      check_idle("lock_loss_idle");
      drained("lock_loss_trace");
    end
  endtask

  initial begin
    int k;
    fork monitor(); join_none
    tick(3);
    check_idle("reset_state");
    rst_n = 1'b1;
    tick(100);
    check_idle("no_lock_100");
    drained("no_lock_trace");

    lock_and_drop(-1, $urandom_range(1, 20));
    wait_done("full_sequence", 100);

    pll_locked = 1'b0;
    tick(6);
    check_idle("drop_in_done");
    lock_and_drop(27, 4);              // lock_s falls in the last cycle of the 5th refresh wait
    lock_and_drop(-1, 3);
    wait_done("relock_sequence", 100);

    pll_locked = 1'b0;
    tick(6);
    for (int i = 0; i < 6; i++) lock_and_drop($urandom_range(1, 48), $urandom_range(0, 6));
    lock_and_drop(1, 3);               // one-cycle lock glitch

    lock_and_drop(-1, 2);
    wait_done("pre_reset_sequence", 100);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    tick();
    rst_n = 1'b1;
    k = cyc;
    for (int m = 0; m < 2; m++) push_seq(m, k, -1);
    wait_done("post_reset_sequence", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_init.md
SDRAM_INIT -- requirements
Module: sdram_init

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 5000, power-up wait in clk cycles (200 us at 25 MHz); legal 1..65535.
REQ-002 SHALL have parameter T_RP, default 1, NOP cycles after PRECHARGE ALL; legal 1..15.
REQ-003 SHALL have parameter T_RFC, default 2, NOP cycles after each AUTO REFRESH; legal 1..15.
REQ-004 SHALL have parameter T_MRD, default 2, NOP cycles after LOAD MODE; legal 1..15.
REQ-005 SHALL have parameter REFRESH_COUNT, default 8, number of AUTO REFRESH commands; legal 1..15.
REQ-006 SHALL have parameter MODE_REG, default 13'h020 (CAS latency 2, sequential, burst 1), value driven on addr during LOAD MODE.
REQ-007 Ports: clk  in  1  25 MHz 0-deg PLL output; one clock, all logic on its rising edge.
REQ-008 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-009 Ports: pll_locked  in  1  PLL lock flag, asynchronous to clk.
REQ-010 Ports: cke  out  1; cs_n, ras_n, cas_n, we_n  out  1 each; ba  out  2; addr  out  13 -- SDRAM command bus.
REQ-011 Ports: init_done  out  1  high when SDRAM is initialised and bus may be handed to the controller.

Function
REQ-012 All outputs SHALL be registered; command encodings {cs_n,ras_n,cas_n,we_n}: NOP 0111, PRECHARGE 0010, AUTO REFRESH 0001, LOAD MODE 0000.
REQ-013 pll_locked SHALL pass a 2-flop synchroniser (lock_s) before use; no other logic samples pll_locked.
REQ-014 States SHALL be WAIT_LOCK, POWERUP, PRECHARGE, WAIT_RP, REFRESH, WAIT_RFC, LOAD_MODE, WAIT_MRD, DONE.
REQ-015 WAIT_LOCK: cke=0, cs_n=1, ras_n/cas_n/we_n=1, ba=0, addr=0; exit to POWERUP on first cycle lock_s=1.
REQ-016 POWERUP SHALL last exactly WAIT_CYCLES cycles with cke=1 and NOP; 16-bit down-counter.
REQ-017 PRECHARGE SHALL last 1 cycle, command PRECHARGE, addr[10]=1 (all banks), other addr bits 0, ba=0.
REQ-018 WAIT_RP SHALL last T_RP cycles of NOP, then REFRESH.
REQ-019 REFRESH SHALL last 1 cycle (AUTO REFRESH), followed by WAIT_RFC of T_RFC NOP cycles; 4-bit refresh counter increments per REFRESH; after the REFRESH_COUNT-th WAIT_RFC go to LOAD_MODE, else REFRESH.
REQ-020 LOAD_MODE SHALL last 1 cycle, command LOAD MODE, ba=0, addr=MODE_REG; then WAIT_MRD for T_MRD NOP cycles, then DONE.
REQ-021 DONE: init_done=1, cke=1, NOP; held indefinitely while lock_s=1.
REQ-022 Cycle count from first POWERUP cycle to first init_done=1 cycle SHALL be WAIT_CYCLES+T_RP+REFRESH_COUNT*(1+T_RFC)+T_MRD+2 (5029 with defaults).
REQ-023 lock_s=0 in any state other than WAIT_LOCK SHALL, on the next edge, force WAIT_LOCK: init_done=0, cke=0, NOP bus, all counters cleared; sequence restarts from POWERUP on relock.
REQ-024 lock_s falling in the same cycle as a counter reaching terminal SHALL take the WAIT_LOCK path (lock loss has priority).
REQ-025 addr/ba SHALL be 0 in every NOP cycle.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force state WAIT_LOCK, synchroniser flops 0, counters 0, cke=0, cs_n=1, ras_n=cas_n=we_n=1, ba=0, addr=0, init_done=0.
REQ-027 Release of rst_n mid-sequence SHALL restart from WAIT_LOCK; no partial sequence resumes.

Verification (WAIT_CYCLES=10, T_RP=1, T_RFC=2, T_MRD=2, REFRESH_COUNT=8 unless stated)
REQ-028 pll_locked held 0 for 100 cycles after reset -> cke=0, NOP bus, init_done=0 throughout.
REQ-029 pll_locked rises -> POWERUP begins 3 edges later; exact command trace PRECHARGE(addr=13'h400), 8 REFRESH spaced 3 cycles, LOAD MODE(addr=13'h020); init_done=1 exactly 39 cycles after first POWERUP cycle.
REQ-030 pll_locked drops during 5th WAIT_RFC -> within 3 edges cke=0, init_done=0; relock -> full sequence repeats with 8 refreshes counted from 0.
REQ-031 rst_n pulsed low for 1 cycle while in DONE -> outputs immediately at reset values; with lock held, full sequence reruns, init_done after 39 POWERUP-relative cycles.
REQ-032 REFRESH_COUNT=1, T_RFC=1, WAIT_CYCLES=1 -> single REFRESH, init_done 8 cycles after first POWERUP cycle.
REQ-033 pll_locked glitch high for 1 cycle -> at most a transient entry, then return to WAIT_LOCK with cke=0; no LOAD MODE issued.
